// File: rtl/arb_pkg.sv
// Shared types and constants for the three-requester round-robin arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    G0   = 2'b01,
    G1   = 2'b10,
    G2   = 2'b11
  } arb_state_t;

  localparam int         NUM_REQ  = 3;
  localparam logic [1:0] LAST_RST = 2'd2;

  // Grant state for a requester index: Gi is encoded as i+1.
  function automatic arb_state_t grant_state(input logic [1:0] idx);
    return arb_state_t'(idx + 2'd1);
  endfunction

endpackage

// File: rtl/arb_rr3_pick.sv
// Combinational round-robin picker: search order last+1, last+2, last (mod 3),
// ignoring any requester set in the exclude mask.
module arb_rr3_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  input  logic [NUM_REQ-1:0] excl,
  output logic               valid,
  output logic [1:0]         idx
);

  logic [NUM_REQ-1:0] cand;
  logic [1:0]         pos;

  always_comb begin
    cand  = req & ~excl;
    valid = 1'b0;
    idx   = 2'd0;
    pos   = 2'd0;
    // Walk from lowest to highest priority so the highest-priority hit wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = 2'((int'(last) + k) % NUM_REQ);
      if (cand[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/arbiter_rr3_ctrl.sv
// Registered 3-way round-robin arbiter (Moore FSM). Define ARB_TIMEOUT_EN to
// build the max-hold timer, forced handoff and preempt pulse.
module arbiter_rr3_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               busy,
  output logic               preempt
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  arb_state_t         state_q, state_d;
  logic [1:0]         last_q, last_d;
  logic [NUM_REQ-1:0] own_mask;
  logic [NUM_REQ-1:0] excl;
  logic [1:0]         own_id;
  logic               in_grant;
  logic               hold_req;
  logic               other_req;
  logic               timeout;
  logic               pick_valid;
  logic [1:0]         pick_idx;

  always_comb begin
    own_mask = '0;
    own_id   = 2'd0;
    unique case (state_q)
      G0:      begin own_mask = 3'b001; own_id = 2'd0; end
      G1:      begin own_mask = 3'b010; own_id = 2'd1; end
      G2:      begin own_mask = 3'b100; own_id = 2'd2; end
      default: begin own_mask = 3'b000; own_id = 2'd0; end
    endcase
  end

  assign in_grant  = (state_q != IDLE);
  assign hold_req  = |(req & own_mask);
  assign other_req = |(req & ~own_mask);

`ifdef ARB_TIMEOUT_EN
  localparam int               CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             preempt_q;

  assign timeout = in_grant && (cnt_q == HOLD_LAST) && other_req;

  always_comb begin
    cnt_d = '0;
    if (in_grant && (state_d == state_q)) begin
      cnt_d = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      preempt_q <= timeout;
    end
  end

  assign preempt = preempt_q;
`else
  assign timeout = 1'b0;
  assign preempt = 1'b0;
`endif

  // On a forced handoff the current holder is excluded even if still requesting.
  assign excl = timeout ? own_mask : '0;

  // While in Gi, last_q already equals i, so one picker serves every state.
  arb_rr3_pick u_pick (
    .req   (req),
    .last  (last_q),
    .excl  (excl),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (!in_grant || !hold_req || timeout) begin
      if (pick_valid) begin
        state_d = grant_state(pick_idx);
        last_d  = pick_idx;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign gnt    = own_mask;
  assign gnt_id = own_id;
  assign busy   = in_grant;

endmodule

// File: tb/tb_arbiter_rr3_ctrl.sv
// Scoreboard bench for arbiter_rr3_ctrl; timeout scenarios follow ARB_TIMEOUT_EN.
module tb_arbiter_rr3_ctrl;

  typedef struct {
    logic [2:0] gnt;
    logic       preempt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] req;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  arbiter_rr3_ctrl #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] id_of(input logic [2:0] g);
    return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
  endfunction

  // Drive req, queue the outputs expected after the next edge, then compare.
  task automatic step(input string tag, input logic [2:0] r, input logic [2:0] g,
                      input logic p = 1'b0);
    exp_t e;
    req = r;
    e.gnt = g;
    e.preempt = p;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 8'd1, 8'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_gnt"}, {5'd0, gnt}, {5'd0, e.gnt});
      check({tag, "_id"}, {6'd0, gnt_id}, {6'd0, id_of(e.gnt)});
      check({tag, "_busy"}, {7'd0, busy}, {7'd0, |e.gnt});
      check({tag, "_preempt"}, {7'd0, preempt}, {7'd0, e.preempt});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", {5'd0, gnt}, 8'd0);
    check("rst_id", {6'd0, gnt_id}, 8'd0);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_preempt", {7'd0, preempt}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All request: 0 first, then rotate on release.
    step("all0", 3'b111, 3'b001);
    step("all1", 3'b111, 3'b001);
    step("rel0", 3'b110, 3'b010);
    step("hold1", 3'b110, 3'b010);
    step("rel1", 3'b100, 3'b100);
    step("hold2", 3'b100, 3'b100);
    step("idle_a", 3'b000, 3'b000);
    step("idle_b", 3'b000, 3'b000);

    // Three-cycle pulse on requester 1.
    for (int i = 0; i < 3; i++) step("pulse1", 3'b010, 3'b010);
    step("pulse_end", 3'b000, 3'b000);

    // Release from G2 with 0 and 1 pending: direct handoff to 0.
    step("g2_a", 3'b100, 3'b100);
    step("g2_b", 3'b100, 3'b100);
    step("g2_hand", 3'b011, 3'b001);
    step("g0_hold", 3'b011, 3'b001);
    step("g0_rel", 3'b010, 3'b010);
    step("idle_c", 3'b000, 3'b000);

`ifdef ARB_TIMEOUT_EN
    // MAX_HOLD=4: holder gets exactly four cycles, then forced handoff.
    step("to_c1", 3'b001, 3'b001);
    step("to_c2", 3'b011, 3'b001);
    step("to_c3", 3'b011, 3'b001);
    step("to_c4", 3'b011, 3'b001);
    step("to_pre", 3'b011, 3'b010, 1'b1);
    step("to_g1a", 3'b011, 3'b010);
    step("to_g1b", 3'b011, 3'b010);
    step("to_g1c", 3'b011, 3'b010);
    step("to_back", 3'b011, 3'b001, 1'b1);
    step("to_after", 3'b011, 3'b001);
    step("to_idle", 3'b000, 3'b000);
`else
    // No timer: the holder keeps the grant until it releases.
    step("burst_c1", 3'b001, 3'b001);
    for (int i = 0; i < 8; i++) step("burst_hold", 3'b011, 3'b001);
    step("burst_rel", 3'b010, 3'b010);
    step("burst_idle", 3'b000, 3'b000);
`endif

    // Lone requester keeps the grant; no preempt without competition.
    for (int i = 0; i < 40; i++) step("solo", 3'b001, 3'b001);
    step("solo_end", 3'b000, 3'b000);

    // Asynchronous reset while in G1.
    step("mid_a", 3'b010, 3'b010);
    step("mid_b", 3'b010, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt", {5'd0, gnt}, 8'd0);
    check("async_busy", {7'd0, busy}, 8'd0);
    check("async_id", {6'd0, gnt_id}, 8'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst", 3'b111, 3'b001);
    step("post_rst2", 3'b111, 3'b001);
    step("post_rel", 3'b000, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/arbiter_rr3_ctrl.md
# arbiter_rr3_ctrl

Registered three-requester round-robin arbiter controlling a single shared resource. It replaces the purely combinational next-state arbitration logic with a clocked Moore controller that owns the state register, the round-robin pointer and an optional maximum-hold timer. It drives one-hot grants and a grant index to the resource mux. It sits between the three requesting units and the shared datapath.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one requester may hold the grant while another is waiting. Legal range 2..255. Used only when the timeout is compiled in.
- CNT_W, $clog2(MAX_HOLD+1): hold-counter width (derived, not overridden).
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset (async assert, sync deassert upstream).
- REQ  input  3  request per requester; bit i = requester i; level-sensitive.
- GNT  output  3  one-hot grant, or all-zero when idle; registered.
- GNT_ID  output  2  index of the granted requester; 2'd0 when idle; registered.
- BUSY  output  1  high while any grant is active; equals |GNT.
- PREEMPT  output  1  one-cycle pulse, high in the first cycle after a timeout-forced handoff.

## Operation
- Moore FSM, 2-bit state: IDLE=2'b00, G0=2'b01, G1=2'b10, G2=2'b11. All outputs are decoded from registered state only.
- LAST[1:0] holds the most recently granted index. It resets to 2, so the first search order is 0, 1, 2.
- Search order is LAST+1, LAST+2, LAST (mod 3). The first asserted REQ in that order wins.
- IDLE: if any REQ bit is high, go to G_winner and set LAST to the winner. Otherwise stay in IDLE.
- G_i with REQ[i] high and no timeout: stay in G_i. Grant is held for the whole burst.
- G_i with REQ[i] low: hand off directly, with no idle cycle, to the winner of the search with LAST=i. If no other REQ is high, go to IDLE.
- G_i with timeout reached and another REQ high: forced handoff to the winner among the other requesters, excluding i. REQ[i] staying high does not keep the grant. LAST updates to the winner and PREEMPT pulses.
- Simultaneous release by i and new requests: normal handoff rule applies. Requester i is treated as lowest priority.
- Reset mid-burst: GNT drops to 0 asynchronously and all registers return to reset values. Requesters must re-arbitrate.

## Timing
- Reset values: state=IDLE, GNT=3'b000, GNT_ID=2'd0, BUSY=0, PREEMPT=0, LAST=2'd2, hold counter=0.
- Request-to-grant latency: 1 cycle. REQ sampled high at edge n gives GNT valid after edge n.
- Release-to-handoff latency: 1 cycle. Grants never overlap; GNT stays one-hot or zero on every cycle.
- Hold counter clears on every state change and increments each cycle in G_i. It saturates at MAX_HOLD-1.
- The timeout condition is counter==MAX_HOLD-1 with another request pending. The handoff happens at the next edge, so the holder gets exactly MAX_HOLD cycles.
- With no competing request, the holder keeps the grant indefinitely; the counter stays saturated.

## Configuration
- ARB_TIMEOUT_EN defined: the hold counter, the forced-handoff path and PREEMPT are implemented as above.
- ARB_TIMEOUT_EN undefined: counter logic is removed, MAX_HOLD is ignored and PREEMPT is tied to 0. The grant is held until REQ[i] drops (pure burst round-robin).

## Structure
- Shared package arb_pkg holds:
  - state typedef arb_state_t (IDLE, G0, G1, G2)
  - NUM_REQ=3
  - reset constant LAST_RST=2'd2
- One natural sub-module: arb_rr3_pick. It is combinational and takes REQ[2:0], LAST[1:0] and an exclude mask. It returns a valid flag and the winning index. The FSM instantiates it once.

## Test plan
- Reset then REQ=3'b111 held: GNT=001 one cycle later, held. Drop REQ[0] -> next cycle GNT=010, then GNT=100 when REQ[1] drops.
- REQ=3'b010 pulsed for 3 cycles, all others 0: GNT=010 for 3 cycles, then GNT=000, BUSY=0, GNT_ID=0.
- G2 active, REQ[2] drops while REQ=3'b011: next GNT=001 (order 0,1,2), no IDLE cycle in between.
- ARB_TIMEOUT_EN, MAX_HOLD=4, REQ[0] held, REQ[1] asserted at cycle 1: GNT=001 for exactly 4 cycles, then GNT=010 with PREEMPT=1 for one cycle.
- ARB_TIMEOUT_EN, REQ=3'b001 only, held for 40 cycles: GNT=001 throughout, PREEMPT never asserted.
- Assert RST_N=0 mid-burst in G1: GNT=000 immediately, without waiting for a clock edge. After release with REQ=3'b111: GNT=001.
